// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder: state encoding,
// word geometry and the access-check function.
package dmem_responder_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_SHIFT = 2;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WAIT = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Misaligned byte address or word index past the end of the store.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[BYTE_SHIFT-1:0] != '0) ||
               ({{BYTE_SHIFT{1'b0}}, addr[WORD_W-1:BYTE_SHIFT]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Valid/ready request/response bundle between the core memory stage and the
// responder. req_swap exists only when DMEM_SWAP_EN is defined.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
`ifdef DMEM_SWAP_EN
    logic              req_swap;
`endif
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_SWAP_EN
        output req_swap,
`endif
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
`ifdef DMEM_SWAP_EN
        input  req_swap,
`endif
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// DEPTH x 32 word store: synchronous write, combinational read, word i
// initialised to i at elaboration and untouched by reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     idx_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_fill();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) m[i] = WORD_W'(i);
        return m;
    endfunction

    mem_t mem_q = init_fill();

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[idx_i] <= wdata_i;
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits WAIT_CYCLES, accesses
// the store and holds the response until taken. Optional swap: DMEM_SWAP_EN.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input logic              clk_i,
    input logic              rst_ni,
    dmem_responder_if.slave  bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              write_q, swap_q;
    logic [WORD_W-1:0] addr_q, wdata_q;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              swap_in, accept;
    logic              acc_go, acc_write, acc_swap, acc_err, mem_we;
    logic [WORD_W-1:0] acc_addr, acc_wdata, mem_rdata;

`ifdef DMEM_SWAP_EN
    assign swap_in = bus.req_swap;
`else
    assign swap_in = 1'b0;
`endif

    assign accept = (state_q == ST_IDLE) && bus.req_valid;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        acc_go    = 1'b0;
        acc_write = write_q;
        acc_swap  = swap_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                if (WAIT_CYCLES == 0) begin
                    // Zero wait states: access straight from the request bus.
                    acc_go    = 1'b1;
                    acc_write = bus.req_write;
                    acc_swap  = swap_in;
                    acc_addr  = bus.req_addr;
                    acc_wdata = bus.req_wdata;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_go  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: if (bus.rsp_ready) begin
                state_d = ST_IDLE;
                rdata_d = '0;
                err_d   = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        acc_err = addr_err(acc_addr, DEPTH);
        mem_we  = acc_go && !acc_err && (acc_write || acc_swap);
        if (acc_go) begin
            err_d   = acc_err;
            // Swap returns the old word; a plain store returns zero.
            rdata_d = (acc_err || (acc_write && !acc_swap)) ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            swap_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                write_q <= bus.req_write;
                swap_q  <= swap_in;
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
            end
        end
    end

    dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .idx_i   (acc_addr[AW+BYTE_SHIFT-1:BYTE_SHIFT]),
        .wdata_i (acc_wdata),
        .rdata_o (mem_rdata)
    );

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's data-memory port. It replaces the zero-latency array with a valid/ready request/response slave that has programmable wait states and access checking. It accepts one load or store per transaction, performs the word access after WAIT_CYCLES, and holds the response until the core takes it. It sits between the core's memory stage and the word-addressed data store.

## Interface
- DEPTH, 128, number of 32-bit words in the store
- WAIT_CYCLES, 2, extra cycles between accept and access (0 allowed)
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data
- req_swap  input  1  atomic swap request (present only with DMEM_SWAP_EN)
- rsp_valid  output  1  response present
- rsp_ready  input  1  core accepts response
- rsp_rdata  output  32  load data (old word for swap), 0 on store or error
- rsp_err  output  1  misaligned or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state: IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- IDLE: on req_valid && req_ready, capture write, addr, wdata and swap into registers.
  - WAIT_CYCLES==0: perform the access on the same edge and go to RESP.
  - Otherwise: load the counter with WAIT_CYCLES-1 and go to WAIT.
- WAIT: counter==0 → perform the access and go to RESP; otherwise decrement.
- Access uses word index addr[31:2].
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH).
  - On error: no write, rdata=0, err=1.
  - Load: rdata = mem[index].
  - Store: mem[index] <= wdata, rdata=0.
- RESP: rsp_valid=1. rsp_rdata and rsp_err stay stable until rsp_valid && rsp_ready, then go to IDLE and clear the response outputs.
- Request inputs are ignored outside IDLE.
- Reset mid-transaction:
  - Return to IDLE.
  - If the access has not yet been performed, there is no write.
  - A write already performed remains in memory.
- Memory contents are not affected by rst. At elaboration, word i is initialised to i.

## Timing
- Accept edge E0. Access at edge E0+WAIT_CYCLES. rsp_valid is high in the cycle following that edge.
- Load-to-data latency: WAIT_CYCLES+1 cycles.
- Minimum transaction: WAIT_CYCLES+2 cycles, because RESP→IDLE costs one edge.
- No back-to-back accepts.
- req_ready is decoded from registered state only. It has no combinational path from req_valid.
- rsp_ready held low stalls RESP indefinitely, with outputs frozen.
- rsp_ready high in the first RESP cycle completes the handshake at the next edge.

## Configuration
- DMEM_SWAP_EN defined:
  - The req_swap port exists.
  - A swap (req_swap=1, req_write ignored) returns old mem[index] in rsp_rdata and writes req_wdata at the same edge.
  - Errors behave as for a store: no write, rdata=0.
- Not defined:
  - No req_swap port.
  - Only load and store operations exist.

## Structure
- Shared package holds:
  - the state encoding typedef (IDLE/WAIT/RESP);
  - word width 32;
  - the byte-to-word shift 2;
  - the error-check helper function.
- One sub-module: dmem_array. It is a DEPTH×32 synchronous-write, combinational-read store with its initial fill. The responder owns the FSM, counter, capture registers and checks.

## Test plan
- Load, WAIT_CYCLES=2: request addr=0x10, rsp_ready=1 → rsp_valid 3 cycles after accept, rsp_rdata=4, rsp_err=0.
- Store then load: store 0xDEADBEEF to 0x20, then load 0x20 → 0xDEADBEEF. Neighbouring word 0x24 still reads 9.
- Error cases:
  - Store to 0x22 → rsp_err=1, and word 8 is unchanged.
  - Load from 0x200 (DEPTH=128) → rsp_err=1, rsp_rdata=0.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready=0. Release → IDLE next edge. A new req_valid is ignored until then.
- Reset during WAIT of a store to 0x30 → IDLE, all outputs at reset values, word 12 still reads 12. Swap (DMEM_SWAP_EN) with wdata=7 at 0x14 → rsp_rdata=5, and a subsequent load returns 7.
